// File: rtl/cpu_pkg.sv
// Shared core-wide constants: datapath widths, exception codes and reset values.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned EXC_W  = 5;
  localparam int unsigned TNEW_W = 2;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stage_pipe_reg.sv
// Inter-stage pipeline register with stall hold, flush-to-bubble, Tnew countdown
// and a saturating count of bubble cycles.
module stage_pipe_reg
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN_P    = XLEN,
  parameter int unsigned     SIDE_W    = 1,
  parameter int unsigned     TNEW_P    = TNEW_W,
  parameter int unsigned     EXC_P     = EXC_W,
  parameter int unsigned     CNT_W     = 16,
  parameter bit              KEEP_PC   = 1'b1,
  parameter logic [XLEN_P-1:0] BUBBLE_PC = XLEN_P'(RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [XLEN_P-1:0] in_instr,
  input  logic [XLEN_P-1:0] in_pc,
  input  logic [XLEN_P-1:0] in_alu,
  input  logic [XLEN_P-1:0] in_dm,
  input  logic [SIDE_W-1:0] in_side,
  input  logic [TNEW_P-1:0] in_tnew,
  input  logic [EXC_P-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  output logic [XLEN_P-1:0] out_instr,
  output logic [XLEN_P-1:0] out_pc,
  output logic [XLEN_P-1:0] out_alu,
  output logic [XLEN_P-1:0] out_dm,
  output logic [SIDE_W-1:0] out_side,
  output logic [TNEW_P-1:0] out_tnew,
  output logic [EXC_P-1:0]  out_exc,
  output logic              out_bd,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_d, valid_q;
  logic [XLEN_P-1:0] instr_d, instr_q;
  logic [XLEN_P-1:0] pc_d,    pc_q;
  logic [XLEN_P-1:0] alu_d,   alu_q;
  logic [XLEN_P-1:0] dm_d,    dm_q;
  logic [SIDE_W-1:0] side_d,  side_q;
  logic [TNEW_P-1:0] tnew_d,  tnew_q;
  logic [EXC_P-1:0]  exc_d,   exc_q;
  logic              bd_d,    bd_q;

  // Default is hold, so a stall freezes Tnew as well as the payload.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    dm_d    = dm_q;
    side_d  = side_q;
    tnew_d  = tnew_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = XLEN_P'(NOP_INSTR);
      pc_d    = KEEP_PC ? in_pc : BUBBLE_PC;
      alu_d   = '0;
      dm_d    = '0;
      side_d  = '0;
      tnew_d  = '0;
      exc_d   = EXC_P'(EXC_NONE);
      bd_d    = KEEP_PC ? in_bd : 1'b0;
    end else if (en) begin
      valid_d = in_valid;
      instr_d = in_instr;
      pc_d    = in_pc;
      alu_d   = in_alu;
      dm_d    = in_dm;
      side_d  = in_side;
      tnew_d  = (in_tnew == '0) ? '0 : in_tnew - 1'b1;
      exc_d   = in_exc;
      bd_d    = in_bd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= XLEN_P'(NOP_INSTR);
      pc_q    <= BUBBLE_PC;
      alu_q   <= '0;
      dm_q    <= '0;
      side_q  <= '0;
      tnew_q  <= '0;
      exc_q   <= EXC_P'(EXC_NONE);
      bd_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      dm_q    <= dm_d;
      side_q  <= side_d;
      tnew_q  <= tnew_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
    end
  end

  // Count on the slot being loaded, not the one leaving, so held bubbles keep counting.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .clr_i(reset),
    .inc_i(~valid_d),
    .cnt_o(bubble_cnt)
  );

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;
  assign out_alu   = alu_q;
  assign out_dm    = dm_q;
  assign out_side  = side_q;
  assign out_tnew  = tnew_q;
  assign out_exc   = exc_q;
  assign out_bd    = bd_q;

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Drives two stage_pipe_reg instances (KEEP_PC=1/CNT_W=16 and KEEP_PC=0/CNT_W=3) with
// directed and random traffic and compares every output against a reference model.
module tb_stage_pipe_reg;

  logic        clk;
  logic        reset, en, flush, in_valid, in_bd;
  logic [31:0] in_instr, in_pc, in_alu, in_dm;
  logic [0:0]  in_side;
  logic [1:0]  in_tnew;
  logic [4:0]  in_exc;

  logic        o_valid [2];
  logic [31:0] o_instr [2];
  logic [31:0] o_pc    [2];
  logic [31:0] o_alu   [2];
  logic [31:0] o_dm    [2];
  logic [0:0]  o_side  [2];
  logic [1:0]  o_tnew  [2];
  logic [4:0]  o_exc   [2];
  logic        o_bd    [2];
  logic [15:0] o_cnt0;
  logic [2:0]  o_cnt1;

  // Reference model state per instance.
  logic        m_valid [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_alu   [2];
  logic [31:0] m_dm    [2];
  logic [0:0]  m_side  [2];
  logic [1:0]  m_tnew  [2];
  logic [4:0]  m_exc   [2];
  logic        m_bd    [2];
  int unsigned m_cnt   [2];

  int unsigned total = 0;
  int unsigned bad   = 0;

  stage_pipe_reg #(
    .CNT_W  (16),
    .KEEP_PC(1'b1)
  ) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_alu    (in_alu),
    .in_dm     (in_dm),
    .in_side   (in_side),
    .in_tnew   (in_tnew),
    .in_exc    (in_exc),
    .in_bd     (in_bd),
    .out_valid (o_valid[0]),
    .out_instr (o_instr[0]),
    .out_pc    (o_pc[0]),
    .out_alu   (o_alu[0]),
    .out_dm    (o_dm[0]),
    .out_side  (o_side[0]),
    .out_tnew  (o_tnew[0]),
    .out_exc   (o_exc[0]),
    .out_bd    (o_bd[0]),
    .bubble_cnt(o_cnt0)
  );

  stage_pipe_reg #(
    .CNT_W  (3),
    .KEEP_PC(1'b0)
  ) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_alu    (in_alu),
    .in_dm     (in_dm),
    .in_side   (in_side),
    .in_tnew   (in_tnew),
    .in_exc    (in_exc),
    .in_bd     (in_bd),
    .out_valid (o_valid[1]),
    .out_instr (o_instr[1]),
    .out_pc    (o_pc[1]),
    .out_alu   (o_alu[1]),
    .out_dm    (o_dm[1]),
    .out_side  (o_side[1]),
    .out_tnew  (o_tnew[1]),
    .out_exc   (o_exc[1]),
    .out_bd    (o_bd[1]),
    .bubble_cnt(o_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the spec rules, clock the DUTs, compare everything.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      bit          keep = (i == 0);
      int unsigned cmax = (i == 0) ? 65535 : 7;
      if (reset) begin
        m_valid[i] = 0; m_instr[i] = 0; m_pc[i] = 32'h3000; m_alu[i] = 0; m_dm[i] = 0;
        m_side[i] = 0; m_tnew[i] = 0; m_exc[i] = 0; m_bd[i] = 0; m_cnt[i] = 0;
      end else begin
        if (flush) begin
          m_valid[i] = 0; m_instr[i] = 0; m_alu[i] = 0; m_dm[i] = 0;
          m_side[i] = 0; m_tnew[i] = 0; m_exc[i] = 0;
          m_pc[i] = keep ? in_pc : 32'h3000;
          m_bd[i] = keep ? in_bd : 1'b0;
        end else if (en) begin
          m_valid[i] = in_valid; m_instr[i] = in_instr; m_pc[i] = in_pc; m_alu[i] = in_alu;
          m_dm[i] = in_dm; m_side[i] = in_side; m_exc[i] = in_exc; m_bd[i] = in_bd;
          m_tnew[i] = (in_tnew == 0) ? 2'd0 : 2'(int'(in_tnew) - 1);
        end
        if (!m_valid[i] && m_cnt[i] < cmax) m_cnt[i] = m_cnt[i] + 1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("d%0d.valid", i), 32'(o_valid[i]), 32'(m_valid[i]));
      check_val($sformatf("d%0d.instr", i), o_instr[i], m_instr[i]);
      check_val($sformatf("d%0d.pc", i), o_pc[i], m_pc[i]);
      check_val($sformatf("d%0d.alu", i), o_alu[i], m_alu[i]);
      check_val($sformatf("d%0d.dm", i), o_dm[i], m_dm[i]);
      check_val($sformatf("d%0d.side", i), 32'(o_side[i]), 32'(m_side[i]));
      check_val($sformatf("d%0d.tnew", i), 32'(o_tnew[i]), 32'(m_tnew[i]));
      check_val($sformatf("d%0d.exc", i), 32'(o_exc[i]), 32'(m_exc[i]));
      check_val($sformatf("d%0d.bd", i), 32'(o_bd[i]), 32'(m_bd[i]));
    end
    check_val("d0.cnt", 32'(o_cnt0), m_cnt[0]);
    check_val("d1.cnt", 32'(o_cnt1), m_cnt[1]);
  endtask

  task automatic rand_payload();
    in_instr = $urandom;
    in_pc    = $urandom;
    in_alu   = $urandom;
    in_dm    = $urandom;
    in_side  = 1'($urandom_range(0, 1));
    in_tnew  = 2'($urandom_range(0, 3));
    in_exc   = 5'($urandom_range(0, 31));
    in_bd    = 1'($urandom_range(0, 1));
  endtask

  initial begin
    reset = 1; en = 0; flush = 0; in_valid = 0;
    rand_payload();

    // Reset for two cycles.
    step();
    step();
    check_val("rst.valid", 32'(o_valid[0]), 32'd0);
    check_val("rst.pc", o_pc[0], 32'h3000);
    check_val("rst.instr", o_instr[0], 32'h0);
    check_val("rst.cnt", 32'(o_cnt0), 32'd0);

    // Single load with Tnew decrement.
    reset = 0; en = 1; in_valid = 1;
    in_instr = 32'h0043_0821; in_pc = 32'h3004; in_tnew = 2'd2;
    step();
    check_val("load.instr", o_instr[0], 32'h0043_0821);
    check_val("load.pc", o_pc[0], 32'h3004);
    check_val("load.tnew", 32'(o_tnew[0]), 32'd1);
    check_val("load.valid", 32'(o_valid[0]), 32'd1);

    // Tnew=0 stays 0; stall holds while inputs change.
    in_tnew = 2'd0; in_instr = 32'h1234_5678; in_pc = 32'h3008;
    step();
    check_val("sat.tnew", 32'(o_tnew[0]), 32'd0);
    en = 0;
    for (int k = 0; k < 3; k++) begin
      rand_payload();
      step();
    end
    check_val("stall.instr", o_instr[0], 32'h1234_5678);
    check_val("stall.tnew", 32'(o_tnew[0]), 32'd0);
    check_val("stall.cnt", 32'(o_cnt0), 32'd0);

    // Flush with en=1: bubble, pc/bd behaviour depends on KEEP_PC.
    flush = 1; en = 1; in_pc = 32'h3010; in_bd = 1; in_exc = 5'd12;
    step();
    check_val("flush.instr", o_instr[0], 32'h0);
    check_val("flush.valid", 32'(o_valid[0]), 32'd0);
    check_val("flush.exc", 32'(o_exc[0]), 32'd0);
    check_val("flush.pc_keep", o_pc[0], 32'h3010);
    check_val("flush.bd_keep", 32'(o_bd[0]), 32'd1);
    check_val("flush.cnt", 32'(o_cnt0), 32'd1);
    check_val("flush.pc_nokeep", o_pc[1], 32'h3000);
    check_val("flush.bd_nokeep", 32'(o_bd[1]), 32'd0);

    // Counter saturation on the 3-bit instance.
    flush = 0; reset = 1;
    step();
    reset = 0; en = 1; in_valid = 0;
    for (int k = 0; k < 10; k++) begin
      rand_payload();
      step();
    end
    check_val("satcnt.d1", 32'(o_cnt1), 32'd7);
    check_val("satcnt.d0", 32'(o_cnt0), 32'd10);

    // Reset wins over flush while stalled.
    in_valid = 1; rand_payload();
    step();
    reset = 1; flush = 1; en = 0;
    step();
    check_val("rstwin.pc", o_pc[0], 32'h3000);
    check_val("rstwin.cnt", 32'(o_cnt1), 32'd0);
    check_val("rstwin.bd", 32'(o_bd[0]), 32'd0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      reset    = ($urandom_range(0, 49) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      rand_payload();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
